// File: rtl/flag_ctrl.sv
// flag_ctrl: owner of the Z/N/C/V flag register.
// Arbitrates ALU/explicit writes and interrupt save/restore via a shadow stack.
module flag_ctrl #(
  parameter int          DEPTH       = 4,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alu_valid,
  input  logic [3:0]                 alu_flags,
  input  logic [3:0]                 alu_mask,
  output logic                       alu_gnt,
  input  logic                       wr_valid,
  input  logic [3:0]                 wr_flags,
  input  logic [3:0]                 wr_mask,
  output logic                       wr_gnt,
  input  logic                       save_req,
  input  logic                       restore_req,
  output logic                       save_ack,
  output logic                       restore_ack,
  input  logic                       err_clr,
  output logic [3:0]                 flags_out,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     depth_cnt,
  output logic                       stack_full,
  output logic                       stack_empty,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    IDLE, SAVE, RD, WB, ERR
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      flags_q, flags_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      rd_q, rd_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            esav_q, esav_d;
  logic            push;
  logic [3:0]      stack_q [DEPTH];
  logic [AW-1:0]   wr_idx, top_idx;
  logic            full, empty;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign wr_idx  = cnt_q[AW-1:0];
  // At cnt==DEPTH the low bits wrap to 0, so minus one still lands on the top entry
  assign top_idx = cnt_q[AW-1:0] - AW'(1);

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    ovf_d       = ovf_q & ~err_clr;
    unf_d       = unf_q & ~err_clr;
    esav_d      = esav_q;
    alu_gnt     = 1'b0;
    wr_gnt      = 1'b0;
    save_ack    = 1'b0;
    restore_ack = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rst_n) begin
          if (restore_req) begin
            if (empty) begin
              unf_d   = 1'b1;
              esav_d  = 1'b0;
              state_d = ERR;
            end else begin
              cnt_d   = cnt_q - CW'(1);
              rd_d    = stack_q[top_idx];
              state_d = RD;
            end
          end else if (save_req) begin
            if (full) begin
              ovf_d   = 1'b1;
              esav_d  = 1'b1;
              state_d = ERR;
            end else begin
              state_d = SAVE;
            end
          end else if (wr_valid) begin
            wr_gnt  = 1'b1;
            flags_d = (flags_q & ~wr_mask) | (wr_flags & wr_mask);
          end else if (alu_valid) begin
            alu_gnt = 1'b1;
            flags_d = (flags_q & ~alu_mask) | (alu_flags & alu_mask);
          end
        end
      end
      SAVE: begin
        push     = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        save_ack = 1'b1;
        state_d  = IDLE;
      end
      RD: begin
        state_d = WB;
      end
      WB: begin
        flags_d     = rd_q;
        restore_ack = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        save_ack    = esav_q;
        restore_ack = ~esav_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      flags_q <= RESET_FLAGS;
      cnt_q   <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      esav_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      esav_q  <= esav_d;
    end
  end

  // Stack contents need no reset; depth_cnt alone defines validity
  always_ff @(posedge clk) begin
    if (push) stack_q[wr_idx] <= flags_q;
  end

  assign flags_out   = flags_q;
  assign busy        = (state_q != IDLE);
  assign depth_cnt   = cnt_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign ovf_err     = ovf_q;
  assign unf_err     = unf_q;

endmodule

// File: tb/tb_flag_ctrl.sv
// tb_flag_ctrl: table vectors, directed sequences and random stimulus
// checked against a transaction-timeline model of flag_ctrl.
module tb_flag_ctrl;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_valid, wr_valid, save_req, restore_req, err_clr;
  logic [3:0] alu_flags, alu_mask, wr_flags, wr_mask;
  logic       alu_gnt, wr_gnt, save_ack, restore_ack, busy;
  logic [3:0] flags_out;
  logic [2:0] depth_cnt;
  logic       stack_full, stack_empty, ovf_err, unf_err;

  flag_ctrl #(.DEPTH(DEPTH), .RESET_FLAGS(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_flags(alu_flags), .alu_mask(alu_mask),
    .alu_gnt(alu_gnt),
    .wr_valid(wr_valid), .wr_flags(wr_flags), .wr_mask(wr_mask),
    .wr_gnt(wr_gnt),
    .save_req(save_req), .restore_req(restore_req),
    .save_ack(save_ack), .restore_ack(restore_ack),
    .err_clr(err_clr), .flags_out(flags_out), .busy(busy),
    .depth_cnt(depth_cnt), .stack_full(stack_full),
    .stack_empty(stack_empty), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: architectural state plus a timeline of scheduled events
  logic [3:0] m_flags;
  logic [3:0] m_stk[$];
  bit         m_ovf, m_unf;
  int         cyc = 0;
  int         idle_at, sack_c, rack_c, fload_c, push_c;
  logic [3:0] fload_v, push_v;

  // Snapshot of DUT outputs taken at the falling edge of each step
  logic       s_alu, s_wr, s_sack, s_rack, s_busy;
  logic [3:0] s_flags;
  logic [2:0] s_depth;

  typedef struct {
    bit         av;
    logic [3:0] af, am;
    bit         wv;
    logic [3:0] wf, wm;
    bit         eag, ewg;
    logic [3:0] ef;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = 4'b0000;
    m_stk   = {};
    m_ovf   = 0;
    m_unf   = 0;
    idle_at = 0;
    sack_c  = -1;
    rack_c  = -1;
    fload_c = -1;
    push_c  = -1;
  endtask

  task automatic clr();
    alu_valid = 0; wr_valid = 0; save_req = 0;
    restore_req = 0; err_clr = 0;
    alu_flags = 0; alu_mask = 0; wr_flags = 0; wr_mask = 0;
  endtask

  task automatic step();
    bit idle, ag, wg;
    logic [15:0] act, exp;
    @(negedge clk);
    s_alu = alu_gnt; s_wr = wr_gnt; s_sack = save_ack;
    s_rack = restore_ack; s_busy = busy;
    s_flags = flags_out; s_depth = depth_cnt;
    idle = rst_n && (cyc >= idle_at);
    wg = idle && !restore_req && !save_req && wr_valid;
    ag = idle && !restore_req && !save_req && !wr_valid && alu_valid;
    exp = {ag, wg, cyc == sack_c, cyc == rack_c, cyc < idle_at,
           m_flags, 3'(m_stk.size()), m_stk.size() == DEPTH,
           m_stk.size() == 0, m_ovf, m_unf};
    act = {alu_gnt, wr_gnt, save_ack, restore_ack, busy, flags_out,
           depth_cnt, stack_full, stack_empty, ovf_err, unf_err};
    chk("model", act, exp);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (cyc == push_c) m_stk.push_back(push_v);
      if (cyc == fload_c) m_flags = fload_v;
      if (err_clr) begin m_ovf = 0; m_unf = 0; end
      if (idle) begin
        if (restore_req) begin
          if (m_stk.size() == 0) begin
            m_unf = 1; rack_c = cyc + 1; idle_at = cyc + 2;
          end else begin
            fload_v = m_stk.pop_back();
            rack_c = cyc + 2; fload_c = cyc + 2; idle_at = cyc + 3;
          end
        end else if (save_req) begin
          sack_c = cyc + 1; idle_at = cyc + 2;
          if (m_stk.size() == DEPTH) m_ovf = 1;
          else begin push_c = cyc + 1; push_v = m_flags; end
        end else if (wg) begin
          m_flags = (m_flags & ~wr_mask) | (wr_flags & wr_mask);
        end else if (ag) begin
          m_flags = (m_flags & ~alu_mask) | (alu_flags & alu_mask);
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wr_set(input logic [3:0] v);
    wr_valid = 1; wr_flags = v; wr_mask = 4'b1111;
    step();
    clr();
  endtask

  initial begin
    vt[0] = '{1, 4'b0000, 4'b1111, 1, 4'b0101, 4'b0011, 0, 1, 4'b1001};
    vt[1] = '{1, 4'b0000, 4'b1111, 0, 4'b0000, 4'b0000, 1, 0, 4'b0000};
    vt[2] = '{0, 4'b0000, 4'b0000, 1, 4'b1111, 4'b0000, 0, 1, 4'b0000};
    vt[3] = '{1, 4'b0110, 4'b0110, 0, 4'b0000, 4'b0000, 1, 0, 4'b0110};
    vt[4] = '{0, 4'b0000, 4'b0000, 1, 4'b1001, 4'b1000, 0, 1, 4'b1110};
    vt[5] = '{1, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 1, 0, 4'b1110};
    vt[6] = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 4'b1110};
    vt[7] = '{0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b1010, 0, 1, 4'b0100};
    vt[8] = '{1, 4'b0110, 4'b1111, 0, 4'b0000, 4'b0000, 1, 0, 4'b0110};

    rst_n = 0;
    clr();
    model_reset();
    #1;
    chk("rst_flags", 16'(flags_out), 16'h0);
    chk("rst_depth", 16'(depth_cnt), 16'h0);
    chk("rst_empty", 16'(stack_empty), 16'h1);
    alu_valid = 1; alu_flags = 4'b1010; alu_mask = 4'b1111;
    #1;
    chk("rst_nogrant", 16'(alu_gnt), 16'h0);
    @(posedge clk); #1;
    step();
    step();
    rst_n = 1;

    // First ALU update after reset
    step();
    chk("alu_gnt", 16'(s_alu), 16'h1);
    clr();
    chk("alu_flags", 16'(flags_out), 16'b1010);

    foreach (vt[i]) begin
      alu_valid = vt[i].av; alu_flags = vt[i].af; alu_mask = vt[i].am;
      wr_valid = vt[i].wv; wr_flags = vt[i].wf; wr_mask = vt[i].wm;
      step();
      chk($sformatf("vec%0d_gnt", i), 16'({s_alu, s_wr}),
          16'({vt[i].eag, vt[i].ewg}));
      chk($sformatf("vec%0d_flags", i), 16'(flags_out), 16'(vt[i].ef));
    end
    clr();

    // Save/restore round trip with latency checks
    save_req = 1;
    step();
    clr();
    step();
    chk("save_ack_t1", 16'(s_sack), 16'h1);
    chk("save_depth", 16'(depth_cnt), 16'h1);
    wr_set(4'b1111);
    restore_req = 1;
    step();
    clr();
    step();
    chk("rack_t1", 16'(s_rack), 16'h0);
    step();
    chk("rack_t2", 16'(s_rack), 16'h1);
    chk("rack_t2_flags", 16'(s_flags), 16'b1111);
    chk("restore_flags", 16'(flags_out), 16'b0110);
    chk("restore_depth", 16'(depth_cnt), 16'h0);

    // Fill, overflow, LIFO drain, underflow, clear
    for (int i = 0; i < 5; i++) begin
      wr_set(4'(i + 1));
      save_req = 1;
      step();
      clr();
      step();
      chk($sformatf("fill%0d_ack", i), 16'(s_sack), 16'h1);
      chk($sformatf("fill%0d_depth", i), 16'(depth_cnt),
          16'(i < 4 ? i + 1 : 4));
    end
    chk("full", 16'(stack_full), 16'h1);
    chk("ovf", 16'(ovf_err), 16'h1);
    for (int i = 0; i < 4; i++) begin
      restore_req = 1;
      step();
      clr();
      step();
      step();
      chk($sformatf("lifo%0d", i), 16'(flags_out), 16'(4 - i));
    end
    restore_req = 1;
    step();
    clr();
    step();
    chk("unf_ack", 16'(s_rack), 16'h1);
    chk("unf_err", 16'(unf_err), 16'h1);
    chk("unf_flags", 16'(flags_out), 16'h1);
    err_clr = 1;
    step();
    clr();
    chk("err_clr", 16'({ovf_err, unf_err}), 16'h0);

    // Restore beats save and ALU; ALU waits for IDLE
    save_req = 1;
    step();
    clr();
    step();
    save_req = 1; restore_req = 1; alu_valid = 1;
    step();
    chk("prio_alu_t0", 16'(s_alu), 16'h0);
    save_req = 0; restore_req = 0;
    step();
    chk("prio_t1", 16'({s_busy, s_alu}), 16'b10);
    step();
    chk("prio_t2", 16'({s_busy, s_alu}), 16'b10);
    step();
    chk("prio_t3", 16'({s_busy, s_alu}), 16'b01);
    chk("prio_depth", 16'(depth_cnt), 16'h0);
    clr();

    // Reset asserted while in RD aborts the restore
    wr_set(4'b1100);
    save_req = 1;
    step();
    clr();
    step();
    restore_req = 1;
    step();
    clr();
    rst_n = 0;
    #1;
    chk("rrd_flags", 16'(flags_out), 16'h0);
    chk("rrd_state", 16'({busy, restore_ack}), 16'h0);
    chk("rrd_depth", 16'(depth_cnt), 16'h0);
    model_reset();
    step();
    step();
    chk("rrd_noack", 16'(s_rack), 16'h0);
    rst_n = 1;

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      restore_req = ($urandom_range(0, 7) == 0);
      save_req    = ($urandom_range(0, 6) == 0);
      wr_valid    = ($urandom_range(0, 2) == 0);
      alu_valid   = ($urandom_range(0, 1) == 0);
      err_clr     = ($urandom_range(0, 15) == 0);
      wr_flags    = 4'($urandom);
      wr_mask     = 4'($urandom);
      alu_flags   = 4'($urandom);
      alu_mask    = 4'($urandom);
      step();
    end
    clr();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flag_ctrl.md
Name: flag_ctrl

Overview:
Controller that owns the 4-bit processor flag register (Z,N,C,V). It arbitrates flag writes from the ALU, explicit flag-write instructions, and interrupt save/restore. Save/restore go through a shadow flag stack. It sits between the execute stage and the interrupt sequencer, and is the only writer of architectural flags.

Parameters:
DEPTH, 4, shadow stack entries (power of 2, >=2)
RESET_FLAGS, 4'b0000, flag value after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU flag-update request
alu_flags  in  4  ALU result flags
alu_mask  in  4  per-bit update enable for ALU flags
alu_gnt  out  1  ALU update accepted this cycle (combinational)
wr_valid  in  1  explicit flag-write instruction request
wr_flags  in  4  explicit flag value
wr_mask  in  4  per-bit update enable for wr_flags
wr_gnt  out  1  explicit write accepted this cycle (combinational)
save_req  in  1  interrupt entry: push flags
restore_req  in  1  interrupt return: pop flags
save_ack  out  1  one-cycle pulse, save finished
restore_ack  out  1  one-cycle pulse, restore finished
err_clr  in  1  clear sticky error bits
flags_out  out  4  architectural flags (registered)
busy  out  1  FSM not in IDLE
depth_cnt  out  $clog2(DEPTH)+1  occupied stack entries
stack_full  out  1  depth_cnt==DEPTH
stack_empty  out  1  depth_cnt==0
ovf_err  out  1  sticky: save attempted while full
unf_err  out  1  sticky: restore attempted while empty

Behaviour:
- Reset (async, rst_n=0): flags_out=RESET_FLAGS, state=IDLE, depth_cnt=0, acks=0, errors=0, busy=0. Stack contents are don't-care. Reset mid-save/restore aborts the operation with no ack.
- FSM states: IDLE, SAVE, RD, WB, ERR.
- In IDLE, requests have fixed priority: restore_req > save_req > wr_valid > alu_valid. Exactly one is granted per cycle; losers are not granted and must hold their request.
- Outside IDLE, all grants are 0 and no request is accepted.
- Masked update for wr/alu grant: flags_next = (flags & ~mask) | (src & mask). The result is visible on flags_out in the cycle after the grant. A mask of 0 is granted and has no effect.
- Save when not full: IDLE->SAVE. In SAVE:
  - stack[depth_cnt] <= flags_out (value at grant, unchanged since).
  - depth_cnt++.
  - save_ack=1.
  - SAVE->IDLE.
  - Flags are unchanged.
- Restore when not empty:
  - IDLE->RD: depth_cnt--, read data from stack[depth_cnt-1] is registered.
  - RD->WB: flags_out <= registered data, restore_ack=1.
  - WB->IDLE.
  - Latency: request cycle T, ack at T+2, new flags visible at T+3.
- Save while full:
  - ovf_err set.
  - IDLE->ERR, save_ack=1 in ERR, ERR->IDLE.
  - No push; depth_cnt and flags are unchanged.
- Restore while empty:
  - unf_err set.
  - IDLE->ERR, restore_ack=1 in ERR, ERR->IDLE.
  - Flags are unchanged.
- err_clr clears both sticky bits. If a new error is set in the same cycle, the set wins.
- busy = (state != IDLE).
- stack_full and stack_empty are decoded from the registered depth_cnt.
- No wrap-around: depth_cnt saturates at 0 and at DEPTH by rule.

Test Plan:
- Reset with RESET_FLAGS=4'b0000 -> flags_out=0, depth_cnt=0, stack_empty=1, no grants while rst_n=0. Then alu_valid, alu_flags=4'b1010, mask=4'b1111 -> alu_gnt=1, flags_out=4'b1010 next cycle.
- Flags=4'b1010; wr_valid and alu_valid in the same cycle; wr_flags=4'b0101, wr_mask=4'b0011 -> wr_gnt=1, alu_gnt=0, flags_out=4'b1001. ALU is granted the following cycle.
- Flags=4'b0110; save_req -> save_ack at T+1, depth_cnt=1. Then wr sets flags 4'b1111, then restore_req -> restore_ack at T+2, flags_out=4'b0110 at T+3, depth_cnt=0.
- DEPTH=4: five saves -> 4th gives stack_full=1, 5th gives ovf_err=1 with ack and depth_cnt stays 4. Four restores return values in LIFO order, a 5th sets unf_err. err_clr clears both.
- save_req, restore_req and alu_valid together with depth 1 -> restore wins, busy=1 for 2 cycles, alu_gnt=0 until IDLE.
- rst_n pulsed low during RD -> immediate reset values, no restore_ack, depth_cnt=0.
